// File: rtl/bytes2bits_stream_pkg.sv
// bytes2bits_pkg: shared sizing helpers, FSM state encoding and byte bit-reversal for bytes2bits_stream
package bytes2bits_pkg;
  typedef enum logic [0:0] {B2B_RUN, B2B_FLUSH} b2b_state_e;
  function automatic int b2b_buf_w(input int in_bytes, input int out_bits);
    return 8 * in_bytes + out_bits;
  endfunction
  function automatic int b2b_cnt_w(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction
endpackage

// File: rtl/bytes2bits_stream_if.sv
// bytes2bits_stream_if: beat-in / chunk-out valid-ready bundle for bytes2bits_stream
// Signals: in_valid/in_ready/in_data/in_last (byte beats), out_valid/out_ready/out_data/out_last (bit chunks)
// Modports: master drives beats and consumes chunks, slave is the gearbox side
interface bytes2bits_stream_if #(
  parameter int IN_BYTES = 4,
  parameter int OUT_BITS = 12
);
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [8*IN_BYTES-1:0] in_data;
  logic [OUT_BITS-1:0] out_data;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input in_ready, out_valid, out_data, out_last
  );
  modport slave (
    input in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bytes2bits_stream_shift_buf.sv
// b2b_shift_buf: bit buffer with fill count; pops OUT_BITS from the bottom, then inserts a beat just above what is left
// Ports: clk, rst_n (sync, active-low), pop, push, din (beat), data (buffer, oldest bit at 0), count (valid bits)
module b2b_shift_buf #(
  parameter int IN_W = 32,
  parameter int OUT_BITS = 12,
  parameter int BUF_W = 44,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pop,
  input  logic             push,
  input  logic [IN_W-1:0]  din,
  output logic [BUF_W-1:0] data,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] OB = CNT_W'(OUT_BITS);
  localparam logic [CNT_W-1:0] IW = CNT_W'(IN_W);
  logic [BUF_W-1:0] popped;
  logic [CNT_W-1:0] cnt_pop;
  // bits above count are always zero, so the insert can simply be OR-ed in
  always_comb begin
    popped = pop ? data >> OUT_BITS : data;
    cnt_pop = pop ? (count > OB ? count - OB : '0) : count;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      count <= '0;
    end else begin
      data <= push ? popped | (BUF_W'(din) << cnt_pop) : popped;
      count <= push ? cnt_pop + IW : cnt_pop;
    end
  end
endmodule

// File: rtl/bytes2bits_stream.sv
// bytes2bits_stream: streaming gearbox from IN_BYTES-byte beats to OUT_BITS-bit chunks, LSB-first, zero-padded flush
// Ports: clk, rst_n (sync, active-low), bus (bytes2bits_stream_if.slave)
// Build option: define B2B_BIT_REVERSE_EN to bit-reverse every input byte for MSB-first encoders
module bytes2bits_stream
  import bytes2bits_pkg::*;
#(
  parameter int IN_BYTES = 4,
  parameter int OUT_BITS = 12
) (
  input logic clk,
  input logic rst_n,
  bytes2bits_stream_if.slave bus
);
  localparam int IN_W = 8 * IN_BYTES;
  localparam int BUF_W = b2b_buf_w(IN_BYTES, OUT_BITS);
  localparam int CNT_W = b2b_cnt_w(BUF_W);
  localparam logic [0:0] ST_RUN = B2B_RUN;
  localparam logic [0:0] ST_FLUSH = B2B_FLUSH;
  localparam logic [CNT_W-1:0] OB = CNT_W'(OUT_BITS);
  logic [0:0] state;
  logic [BUF_W-1:0] buf_q;
  logic [CNT_W-1:0] count;
  logic [IN_W-1:0] din;
  logic pop, push;
`ifdef B2B_BIT_REVERSE_EN
  always_comb begin
    din = '0;
    for (int i = 0; i < IN_BYTES; i++) din[8*i +: 8] = bit_rev8(bus.in_data[8*i +: 8]);
  end
`else
  assign din = bus.in_data;
`endif
  // in_ready looks only at registered state so out_ready never reaches it combinationally
  always_comb begin
    bus.in_ready = rst_n && state == ST_RUN && count <= OB;
    bus.out_valid = count >= OB || (state == ST_FLUSH && count != '0);
    bus.out_last = bus.out_valid && state == ST_FLUSH && count <= OB;
    bus.out_data = buf_q[OUT_BITS-1:0] & ~({OUT_BITS{1'b1}} << count);
    pop = bus.out_valid && bus.out_ready;
    push = bus.in_valid && bus.in_ready;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else if (push && bus.in_last) state <= ST_FLUSH;
    else if (pop && bus.out_last) state <= ST_RUN;
  end
  b2b_shift_buf #(
    .IN_W(IN_W),
    .OUT_BITS(OUT_BITS),
    .BUF_W(BUF_W),
    .CNT_W(CNT_W)
  ) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .pop(pop),
    .push(push),
    .din(din),
    .data(buf_q),
    .count(count)
  );
endmodule

// File: doc/bytes2bits_stream.md
Name: bytes2bits_stream

Overview:
Streaming, parametrised successor to the combinational byte-to-bit packer. Accepts IN_BYTES bytes per beat over valid/ready and emits OUT_BITS-bit chunks over valid/ready. Bit order is LSB-first, little-endian: byte i occupies bits [8i+7:8i] of the stream. It is a gearbox in front of the ByteDecode/decompress stages and supports arbitrary IN_W/OUT_BITS ratios, backpressure and zero-padded end-of-message flush.

Parameters:
IN_BYTES, 4, bytes per input beat (1..16); IN_W = 8*IN_BYTES.
OUT_BITS, 12, bits per output chunk (1..64).
BUF_W, IN_W+OUT_BITS, derived; internal bit-buffer width, not overridable.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid && in_ready.
in_data  in  IN_W  byte i at [8i+7:8i].
in_last  in  1  final beat of message.
out_valid  out  1  output chunk valid.
out_ready  in  1  chunk consumed when out_valid && out_ready.
out_data  out  OUT_BITS  next OUT_BITS stream bits, stream bit k at out_data[k].
out_last  out  1  final chunk of message.

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low. On reset: buffer=0, count=0, state=RUN, in_ready=0 during reset, out_valid=0, out_last=0, out_data=0.
- State: buf[BUF_W-1:0] holds valid bits at [count-1:0], with the oldest bit at index 0. count has width $clog2(BUF_W+1).
- FSM RUN/FLUSH. RUN: in_ready = (count <= OUT_BITS), from registered count only, with no combinational out_ready->in_ready path. FLUSH: in_ready=0.
- out_valid = (count >= OUT_BITS) || (state==FLUSH && count>0). out_data = buf[OUT_BITS-1:0] with bits at index >= count forced to 0. It is driven from registers and the masking is combinational.
- out_last = out_valid && state==FLUSH && count <= OUT_BITS.
- Per cycle, pop first, then push. On pop: buf >>= OUT_BITS and count -= min(count, OUT_BITS). On push: in_data is written at bit position count_after_pop and count += IN_W. Simultaneous pop and push in the same cycle is required and must not lose bits.
- Latency: data accepted at edge t is visible as out_valid at t+1 if enough bits are present.
- Push with in_last=1 moves the FSM RUN->FLUSH. If IN_W is a multiple of OUT_BITS, the last full chunk carries out_last.
- FLUSH->RUN occurs when the out_last chunk is popped; count is then 0. Message boundaries never merge.
- in_last on a beat rejected by in_ready=0 is ignored.
- out_data and out_valid stay stable while out_valid && !out_ready (AXI-stream rule). in_valid may deassert without acceptance.
- Reset mid-message discards all buffered bits; the next beat after reset starts a new message.
- Overflow is impossible by construction: max count after push = OUT_BITS + IN_W = BUF_W.

Optional Feature:
Macro B2B_BIT_REVERSE_EN.
- Defined: each input byte is bit-reversed before buffering (MSB-first within byte), for legacy MSB-first encoders. Byte order is unchanged.
- Undefined: no reversal logic; behaviour as above.

Decomposition:
- Package bytes2bits_pkg: function b2b_buf_w(in_bytes, out_bits), function b2b_cnt_w, enum b2b_state_e {B2B_RUN, B2B_FLUSH}, and function bit_rev8.
- One natural sub-module, b2b_shift_buf: buffer plus count, with pop/push/insert-at-offset. FSM and handshakes stay in the top.

Test Plan:
- IN_BYTES=4, OUT_BITS=12. One beat 0x89ABCDEF with last, out_ready=1 -> chunks 0xDEF, 0xABC, 0x089 (zero-padded) with out_last on the third only.
- Two beats: 0x89ABCDEF, then 0x01234567 with last -> 0xDEF, 0xABC, 0x789, 0x456, 0x123, then 0x000 with out_last. Exactly 6 chunks; total ordering is 0x0123456789ABCDEF LSB-first.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 continuous -> in_ready drops once count > 12; out_data is held constant at 0xDEF; no bit is lost after release.
- OUT_BITS=1, IN_BYTES=1, byte 0xA5 with last -> serial 1,0,1,0,0,1,0,1, with out_last on the 8th. With B2B_BIT_REVERSE_EN -> 1,0,1,0,0,1,0,1 reversed = 1,0,1,0,0,1,0,1 (palindrome); repeat with 0x01 -> last bit 1, out_last on the 8th.
- rst_n=0 for 1 cycle mid-message (count=20) -> next cycle out_valid=0, count=0. A new message 0x000000FF with last -> 0x0FF, 0x000, 0x000 with out_last.
- Randomised IN_BYTES in {1,3,4} and OUT_BITS in {1,7,12,32}, random valid/ready -> output bitstream equals the concatenated input bitstream, zero-padded to a multiple of OUT_BITS per message.
